// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// =============================================================================
// alu_cmd_sequencer_if: command/response handshake bundle for alu_cmd_sequencer.
// Rev 1.0
// =============================================================================
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_src_acc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_src_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_cout
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_src_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_cout
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// =============================================================================
// alu_cmd_sequencer: registers commands into an external ALU, captures and holds
// the response. Define ALU_SEQ_FLAGS_EN for rsp_zero/rsp_neg outputs. Rev 1.0
// =============================================================================
module alu_cmd_sequencer #(
  parameter int WIDTH    = 4,
  parameter int SEL_W    = 3,
  parameter int ACC_INIT = 0
) (
  input  wire              clk,
  input  wire              rst_n,
  alu_cmd_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  wire  [WIDTH-1:0] alu_result,
  input  wire              alu_cout,
  output logic [WIDTH-1:0] acc,
  output logic [7:0]       cmd_count
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_neg
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_cmd_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) w_state_nxt = S_DRIVE;
      end
      S_DRIVE: w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The accumulator read for src_acc is the pre-edge value, so back-to-back
  // accumulate commands chain through the last captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
      acc          <= WIDTH'(ACC_INIT);
      cmd_count    <= 8'd0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero     <= 1'b0;
      rsp_neg      <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && bus.cmd_valid) begin
        alu_a   <= bus.cmd_src_acc ? acc : bus.cmd_a;
        alu_b   <= bus.cmd_b;
        alu_sel <= bus.cmd_sel;
      end
      if (r_state == S_DRIVE) begin
        r_rsp_result <= alu_result;
        r_rsp_cout   <= alu_cout;
        acc          <= alu_result;
        r_rsp_valid  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
        rsp_zero     <= (alu_result == '0);
        rsp_neg      <= alu_result[WIDTH-1];
`endif
      end
      if (r_state == S_RESP && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
        cmd_count   <= cmd_count + 8'd1;
      end
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_cout   = r_rsp_cout;

endmodule
`default_nettype wire
